// File: rtl/prio_int_ctrl.sv
// Vectored N-channel priority interrupt controller with per-channel edge/level mode,
// nested in-service tracking and an offer/ack handshake towards the PC source mux.
module prio_int_ctrl #(
  parameter int unsigned         N_CH      = 8,
  parameter int unsigned         A_WIDTH   = 8,
  parameter logic [A_WIDTH-1:0]  VEC_BASE  = 8'hE0,
  parameter int unsigned         VEC_STEP  = 2,
  parameter logic [N_CH-1:0]     EDGE_MASK = {N_CH{1'b1}}
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic [N_CH-1:0]    int_req,
  input  logic               mask_ld,
  input  logic [N_CH-1:0]    mask_in,
  input  logic               ien,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               i_pending,
  output logic [A_WIDTH-1:0] int_vec,
  output logic [N_CH-1:0]    isr_out,
  output logic               spur_ack
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StOffer, StAcked} state_e;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    req_q, req_prev_q;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [N_CH-1:0]    isr_q, isr_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic               pending_q, pending_d;
  logic [A_WIDTH-1:0] vec_q, vec_d;
  logic               spur_q, spur_d;

  logic [N_CH-1:0]    allow, eligible, rise, isr_low, ack_set, ack_mask;
  logic               any_elig, ack_take, seen;
  logic [CW-1:0]      win_idx;
  logic [31:0]        step_off;
  logic [A_WIDTH-1:0] win_vec;

  // A channel may only preempt if it outranks every channel currently in service.
  always_comb begin
    seen  = 1'b0;
    allow = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      seen     = seen | isr_q[i];
      allow[i] = ~seen;
    end
  end

  assign eligible = pend_q & mask_q & allow;
  assign any_elig = |eligible;

  always_comb begin
    win_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = CW'(i);
    end
  end

  assign step_off = 32'(win_idx) * VEC_STEP;
  assign win_vec  = VEC_BASE + A_WIDTH'(step_off);

  assign rise     = req_q & ~req_prev_q;
  assign isr_low  = isr_q & (~isr_q + N_CH'(1));
  assign ack_set  = N_CH'(1) << ch_q;
  assign ack_mask = ack_take ? ack_set : '0;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    vec_d     = vec_q;
    ch_d      = ch_q;
    ack_take  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ien && any_elig) begin
          state_d   = StOffer;
          ch_d      = win_idx;
          vec_d     = win_vec;
          pending_d = 1'b1;
        end
      end
      StOffer: begin
        // Ack wins over a simultaneous withdrawal condition.
        if (int_ack) begin
          ack_take  = 1'b1;
          state_d   = StAcked;
          pending_d = 1'b0;
        end else if (!ien || !mask_q[ch_q] || !pend_q[ch_q]) begin
          state_d   = StIdle;
          pending_d = 1'b0;
        end
      end
      StAcked: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Level channels track the registered request; edge channels latch rises until acked.
  assign pend_d = (EDGE_MASK & ((pend_q & ~ack_mask) | rise)) | (~EDGE_MASK & req_q);
  assign isr_d  = (int_done ? (isr_q & ~isr_low) : isr_q) | ack_mask;
  assign mask_d = mask_ld ? mask_in : mask_q;
  assign spur_d = int_ack && (state_q != StOffer);

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q    <= StIdle;
      req_q      <= '0;
      req_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      isr_q      <= '0;
      ch_q       <= '0;
      pending_q  <= 1'b0;
      vec_q      <= '0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= int_req;
      req_prev_q <= req_q;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      isr_q      <= isr_d;
      ch_q       <= ch_d;
      pending_q  <= pending_d;
      vec_q      <= vec_d;
      spur_q     <= spur_d;
    end
  end

  assign i_pending = pending_q;
  assign int_vec   = vec_q;
  assign isr_out   = isr_q;
  assign spur_ack  = spur_q;

endmodule
